// File: rtl/tlb_pkg.sv
// Shared constants, state encoding and PTE address helper for the TLB refill path.
package tlb_pkg;

    localparam int VPN_W = 8;
    localparam int PPN_W = 8;
    localparam int PTE_V = 15;
    localparam int PTE_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // PTEs are 16-bit words, so the VPN is scaled by two; the add wraps at 2^16.
    function automatic logic [15:0] pte_addr(input logic [15:0] base, input logic [VPN_W-1:0] vpn);
        return base + {7'b0000000, vpn, 1'b0};
    endfunction

endpackage

// File: rtl/tlb_victim_counter.sv
// Round-robin replacement pointer for the TLB; advances once per installed entry.
module tlb_victim_counter #(
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [IDX_W-1:0] count
);

    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] count_d;

    // Next pointer value; natural wrap gives modulo NUM_ENTRIES for a power of two.
    always_comb begin
        if (advance) begin
            count_d = count_q + IDX_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {IDX_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tlb_refill_unit.sv
// TLB miss handler: walks one PTE per miss and either installs the translation or raises a fault.
module tlb_refill_unit
    import tlb_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_valid,
    input  logic [15:0]      miss_vaddr,
    input  logic             flush,
    input  logic [15:0]      ptbr,
    output logic             stall,
    output logic             mem_req,
    output logic [15:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [15:0]      mem_rdata,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_wr_index,
    output logic [7:0]       tlb_wr_vpn,
    output logic [7:0]       tlb_wr_ppn,
    output logic             tlb_wr_writable,
    output logic             fault,
    output logic [15:0]      fault_vaddr
);

    state_e             state_q, state_d;
    logic [15:0]        vaddr_q, vaddr_d;
    logic [PPN_W-1:0]   ppn_q, ppn_d;
    logic               writable_q, writable_d;
    logic               abort_q, abort_d;
    logic               mem_req_q, mem_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               tlb_we_q, tlb_we_d;
    logic               fault_q, fault_d;
    logic [15:0]        fault_vaddr_q, fault_vaddr_d;
    logic               advance_s;
    logic [IDX_W-1:0]   victim_s;
    logic               pte_unused_s;

    assign pte_unused_s = ^mem_rdata[13:8];

    tlb_victim_counter #(
        .IDX_W (IDX_W)
    ) u_victim (
        .clk     (clk),
        .reset   (reset),
        .advance (advance_s),
        .count   (victim_s)
    );

    // Walk sequencing and next values for every registered output.
    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        ppn_d         = ppn_q;
        writable_d    = writable_q;
        abort_d       = abort_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        tlb_we_d      = 1'b0;
        fault_d       = 1'b0;
        fault_vaddr_d = fault_vaddr_q;
        advance_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (miss_valid && !flush) begin
                    vaddr_d    = miss_vaddr;
                    mem_addr_d = pte_addr(ptbr, miss_vaddr[15:8]);
                    mem_req_d  = 1'b1;
                    state_d    = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_d = 1'b1;
                abort_d   = abort_q | flush;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    abort_d   = 1'b0;
                    // A flush anywhere in the request, even on the ack, discards the PTE.
                    if (abort_q || flush) begin
                        state_d = ST_IDLE;
                    end else if (mem_rdata[PTE_V]) begin
                        ppn_d      = mem_rdata[PPN_W-1:0];
                        writable_d = mem_rdata[PTE_W];
                        tlb_we_d   = 1'b1;
                        state_d    = ST_WRITE;
                    end else begin
                        fault_d       = 1'b1;
                        fault_vaddr_d = vaddr_q;
                        state_d       = ST_FAULT;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WRITE: begin
                advance_s = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            vaddr_q       <= 16'h0000;
            ppn_q         <= {PPN_W{1'b0}};
            writable_q    <= 1'b0;
            abort_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 16'h0000;
            tlb_we_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_vaddr_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            ppn_q         <= ppn_d;
            writable_q    <= writable_d;
            abort_q       <= abort_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            tlb_we_q      <= tlb_we_d;
            fault_q       <= fault_d;
            fault_vaddr_q <= fault_vaddr_d;
        end
    end

    assign stall           = (state_q != ST_IDLE) || ((state_q == ST_IDLE) && miss_valid && !flush);
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign tlb_we          = tlb_we_q;
    assign tlb_wr_index    = victim_s;
    assign tlb_wr_vpn      = vaddr_q[15:8];
    assign tlb_wr_ppn      = ppn_q;
    assign tlb_wr_writable = writable_q;
    assign fault           = fault_q;
    assign fault_vaddr     = fault_vaddr_q;

endmodule
